// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake and
// loads the IF/ID register, with a one-entry skid buffer for stalls and drain-on-redirect.
module if_fetch_stage #(
  parameter int unsigned               ADDR_W    = 32,
  parameter int unsigned               DATA_W    = 32,
  parameter logic [ADDR_W-1:0]         RESET_PC  = 32'h0000_0000,
  parameter logic [DATA_W-1:0]         NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hd_hold_pc,
  input  logic              hd_hold_if_id,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_MEM    = 2'd2,
    IFID_SKID   = 2'd3
  } ifid_sel_e;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  state_e            state_r;
  logic              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] target_r;
  logic [ADDR_W-1:0] skid_pc_r;
  logic [DATA_W-1:0] skid_instr_r;
  logic [DATA_W-1:0] if_id_instr_r;
  logic [ADDR_W-1:0] if_id_pc_r;
  logic [ADDR_W-1:0] if_id_pc_plus4_r;
  logic              if_id_valid_r;

  logic              accept_s;
  logic              hold_any_s;
  ifid_sel_e         ifid_sel_s;

  assign accept_s   = req_r & imem_ready;
  assign hold_any_s = hd_hold_pc | hd_hold_if_id;

  // Select what IF/ID captures this cycle; a redirect always squashes to a bubble.
  always_comb begin
    ifid_sel_s = IFID_HOLD;
    if (branch_taken) begin
      ifid_sel_s = IFID_BUBBLE;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (accept_s && !hold_any_s) begin
            ifid_sel_s = IFID_MEM;
          end else if (!hd_hold_if_id) begin
            ifid_sel_s = IFID_BUBBLE;
          end else begin
            ifid_sel_s = IFID_HOLD;
          end
        end
        ST_HOLD: begin
          if (!hold_any_s) begin
            ifid_sel_s = IFID_SKID;
          end else if (!hd_hold_if_id) begin
            ifid_sel_s = IFID_BUBBLE;
          end else begin
            ifid_sel_s = IFID_HOLD;
          end
        end
        ST_DRAIN: begin
          if (!hd_hold_if_id) begin
            ifid_sel_s = IFID_BUBBLE;
          end else begin
            ifid_sel_s = IFID_HOLD;
          end
        end
        default: ifid_sel_s = IFID_BUBBLE;
      endcase
    end
  end

  // Fetch FSM: request/address, skid buffer and pending redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_FETCH;
      req_r        <= 1'b0;
      addr_r       <= RESET_PC;
      target_r     <= '0;
      skid_pc_r    <= '0;
      skid_instr_r <= '0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (branch_taken) begin
            // An un-accepted request must stay on the bus, so park the target.
            if (req_r && !imem_ready) begin
              target_r <= branch_target;
              state_r  <= ST_DRAIN;
            end else begin
              addr_r <= branch_target;
              req_r  <= 1'b1;
            end
          end else if (!req_r) begin
            req_r <= 1'b1;
          end else if (accept_s && hold_any_s) begin
            skid_instr_r <= imem_rdata;
            skid_pc_r    <= addr_r;
            req_r        <= 1'b0;
            state_r      <= ST_HOLD;
          end else if (accept_s) begin
            addr_r <= addr_r + PC_STEP;
          end
        end
        ST_HOLD: begin
          if (branch_taken) begin
            addr_r  <= branch_target;
            req_r   <= 1'b1;
            state_r <= ST_FETCH;
          end else if (!hold_any_s) begin
            addr_r  <= skid_pc_r + PC_STEP;
            req_r   <= 1'b1;
            state_r <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (branch_taken && !accept_s) begin
            target_r <= branch_target;
          end else if (branch_taken) begin
            addr_r  <= branch_target;
            state_r <= ST_FETCH;
          end else if (accept_s) begin
            addr_r  <= target_r;
            state_r <= ST_FETCH;
          end
        end
        default: begin
          state_r <= ST_FETCH;
          req_r   <= 1'b0;
          addr_r  <= RESET_PC;
        end
      endcase
    end
  end

  // IF/ID pipeline register; a bubble keeps the pc fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr_r    <= NOP_INSTR;
      if_id_pc_r       <= '0;
      if_id_pc_plus4_r <= '0;
      if_id_valid_r    <= 1'b0;
    end else begin
      case (ifid_sel_s)
        IFID_MEM: begin
          if_id_instr_r    <= imem_rdata;
          if_id_pc_r       <= addr_r;
          if_id_pc_plus4_r <= addr_r + PC_STEP;
          if_id_valid_r    <= 1'b1;
        end
        IFID_SKID: begin
          if_id_instr_r    <= skid_instr_r;
          if_id_pc_r       <= skid_pc_r;
          if_id_pc_plus4_r <= skid_pc_r + PC_STEP;
          if_id_valid_r    <= 1'b1;
        end
        IFID_BUBBLE: begin
          if_id_instr_r <= NOP_INSTR;
          if_id_valid_r <= 1'b0;
        end
        IFID_HOLD: begin
          if_id_valid_r <= if_id_valid_r;
        end
        default: begin
          if_id_instr_r <= NOP_INSTR;
          if_id_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req       = req_r;
  assign imem_addr      = addr_r;
  assign if_id_instr    = if_id_instr_r;
  assign if_id_pc       = if_id_pc_r;
  assign if_id_pc_plus4 = if_id_pc_plus4_r;
  assign if_id_valid    = if_id_valid_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed pinning sequence then randomized holds,
// redirects, latencies and resets against a queue-based transaction model.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] DKEY   = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hd_hold_pc = 1'b0, hd_hold_if_id = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
  logic        if_id_valid;

  int errors = 0;
  int checks = 0;

  // model state: outstanding request, IF/ID contents, parked instruction, pending redirect
  logic        e_req, e_valid;
  logic [31:0] e_addr, e_instr, e_pc, e_pc4;
  logic [63:0] park[$];
  logic [31:0] redir[$];

  // memory responder state
  int          lat_mode = 0;
  int          wait_left = 0;
  bit          busy = 1'b0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  if_fetch_stage #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hd_hold_pc(hd_hold_pc), .hd_hold_if_id(hd_hold_if_id),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_req = 1'b0; e_addr = RST_PC; e_valid = 1'b0; e_instr = NOP;
    e_pc = 32'h0; e_pc4 = 32'h0;
    park.delete(); redir.delete();
    busy = 1'b0; prev_wait = 1'b0;
  endtask

  task automatic bubble_unless_held(input bit force_bubble);
    if (force_bubble || !hd_hold_if_id) begin
      e_valid = 1'b0; e_instr = NOP;
    end
  endtask

  task automatic compare_all();
    chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
    chk("imem_addr", imem_addr, e_addr);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e_valid});
    chk("if_id_instr", if_id_instr, e_instr);
    chk("if_id_pc", if_id_pc, e_pc);
    chk("if_id_pc_plus4", if_id_pc_plus4, e_pc4);
    if (prev_wait) begin
      chk("req_held", {31'h0, imem_req}, 32'h1);
      chk("addr_stable", imem_addr, prev_addr);
    end
  endtask

  // decide ready/rdata from the request currently on the bus
  task automatic drive_mem();
    if (imem_req === 1'b1) begin
      if (!busy) begin
        busy = 1'b1;
        case (lat_mode)
          0:       wait_left = 0;
          1:       wait_left = 2;
          default: wait_left = $urandom_range(0, 3);
        endcase
      end
      if (wait_left == 0) begin
        imem_ready = 1'b1; imem_rdata = imem_addr ^ DKEY; busy = 1'b0;
      end else begin
        imem_ready = 1'b0; imem_rdata = $urandom; wait_left--;
      end
    end else begin
      busy = 1'b0;
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    prev_wait = (imem_req === 1'b1) && (imem_ready == 1'b0);
    prev_addr = imem_addr;
  endtask

  // transaction-level next state from the current inputs
  task automatic model_next();
    logic        acc;
    logic [63:0] pk;
    acc = e_req && imem_ready;
    if (branch_taken) begin
      bubble_unless_held(1'b1);
      park.delete();
      redir.delete();
      if (e_req && !acc) redir.push_back(branch_target);
      else begin e_addr = branch_target; e_req = 1'b1; end
    end else if (redir.size() > 0) begin
      if (acc) e_addr = redir.pop_front();
      bubble_unless_held(1'b0);
    end else if (park.size() > 0) begin
      if (!hd_hold_pc && !hd_hold_if_id) begin
        pk = park.pop_front();
        e_valid = 1'b1; e_instr = pk[63:32]; e_pc = pk[31:0]; e_pc4 = pk[31:0] + 32'd4;
        e_addr = pk[31:0] + 32'd4; e_req = 1'b1;
      end else bubble_unless_held(1'b0);
    end else if (!e_req) begin
      e_req = 1'b1;
      bubble_unless_held(1'b0);
    end else if (acc && !hd_hold_pc && !hd_hold_if_id) begin
      e_valid = 1'b1; e_instr = imem_rdata; e_pc = e_addr; e_pc4 = e_addr + 32'd4;
      e_addr = e_addr + 32'd4;
    end else if (acc) begin
      park.push_back({imem_rdata, e_addr});
      e_req = 1'b0;
      bubble_unless_held(1'b0);
    end else bubble_unless_held(1'b0);
  endtask

  // called at a negedge; returns at the next negedge
  task automatic step(input bit hp, input bit hi, input bit br, input logic [31:0] tgt);
    compare_all();
    hd_hold_pc = hp; hd_hold_if_id = hi; branch_taken = br; branch_target = tgt;
    drive_mem();
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] tgt;
    model_reset();
    @(negedge clk);
    chk("reset_instr", if_id_instr, NOP);
    chk("reset_pc", if_id_pc, 32'h0);
    rst_n = 1'b1;

    // zero-latency streaming
    lat_mode = 0;
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("lit_pc100", if_id_pc, 32'h0000_0100);
    chk("lit_pc4_104", if_id_pc_plus4, 32'h0000_0104);
    step(0, 0, 0, 32'h0);
    chk("lit_pc104", if_id_pc, 32'h0000_0104);
    // stall while 0x108 is accepted
    step(1, 1, 0, 32'h0);
    chk("lit_hold_pc104", if_id_pc, 32'h0000_0104);
    chk("lit_hold_req0", {31'h0, imem_req}, 32'h0);
    step(1, 1, 0, 32'h0);
    chk("lit_hold2_pc104", if_id_pc, 32'h0000_0104);
    step(0, 0, 0, 32'h0);
    chk("lit_pc108", if_id_pc, 32'h0000_0108);
    chk("lit_instr108", if_id_instr, 32'hDEAD_0108);
    chk("lit_addr10c", imem_addr, 32'h0000_010C);
    step(0, 0, 0, 32'h0);
    chk("lit_pc10c", if_id_pc, 32'h0000_010C);

    // redirect while 0x110 is waiting on 3-cycle memory
    lat_mode = 1;
    step(0, 0, 1, 32'h0000_0200);
    chk("lit_drain_valid0", {31'h0, if_id_valid}, 32'h0);
    chk("lit_drain_addr110", imem_addr, 32'h0000_0110);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("lit_addr200", imem_addr, 32'h0000_0200);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("lit_wait_valid0", {31'h0, if_id_valid}, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("lit_pc200", if_id_pc, 32'h0000_0200);
    chk("lit_valid200", {31'h0, if_id_valid}, 32'h1);

    // branch + hold + accept together
    lat_mode = 0;
    step(1, 1, 1, 32'h0000_0300);
    chk("lit_bh_valid0", {31'h0, if_id_valid}, 32'h0);
    chk("lit_bh_addr300", imem_addr, 32'h0000_0300);
    step(0, 0, 0, 32'h0);
    chk("lit_pc300", if_id_pc, 32'h0000_0300);

    // address wrap
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0);
    chk("lit_wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("lit_wrap_pc4", if_id_pc_plus4, 32'h0);
    chk("lit_wrap_addr", imem_addr, 32'h0);

    // reset in the middle of a wait
    lat_mode = 1;
    step(0, 0, 0, 32'h0);
    reset_mid();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) lat_mode = $urandom_range(0, 2);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8 + ($urandom & 32'h4);
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 11) == 0), tgt);
      if ($urandom_range(0, 999) == 0) reset_mid();
    end
    compare_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
